// File: rtl/ga_pkg.sv
// Shared types for the GA coprocessor request/response path and its arbiter.
// The request/response layouts match what the coprocessor already consumes.
package ga_pkg;

    localparam int unsigned GA_ARB_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        GA_OP_ADD = 2'd0,
        GA_OP_SUB = 2'd1,
        GA_OP_MUL = 2'd2,
        GA_OP_MAC = 2'd3
    } ga_op_e;

    typedef struct packed {
        logic        valid;
        ga_op_e      op;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
    } ga_req_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        busy;
        logic        error;
        logic        overflow;
        logic        underflow;
        logic [31:0] result;
    } ga_resp_t;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_DRAIN = 3'd4
    } ga_arb_state_e;

endpackage

// File: rtl/ga_rr_pick.sv
// Round-robin picker: first set bit strictly after last_idx_i, wrapping.
// Purely combinational; grant_vld_o is low when no request is set.
module ga_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_vec_i,
    input  logic [IdxW-1:0]   last_idx_i,
    output logic              grant_vld_o,
    output logic [IdxW-1:0]   grant_idx_o
);

    int unsigned cand;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        cand        = 0;
        for (int unsigned off = NumReq; off >= 1; off--) begin
            cand = (32'(last_idx_i) + off) % NumReq;
            if (req_vec_i[cand]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/ga_req_arbiter.sv
// Shares one GA coprocessor among NumReq requesters with round-robin grants,
// a bounded response wait, and a saturating count of timed-out transactions.
module ga_req_arbiter
    import ga_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = GA_ARB_TIMEOUT_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ga_req_t                   req_i [NumReq],
    output logic [NumReq-1:0]         req_ready_o,
    output ga_resp_t                  resp_o [NumReq],
    output ga_req_t                   cop_req_o,
    input  ga_resp_t                  cop_resp_i,
    output logic [$clog2(NumReq)-1:0] grant_idx_o,
    output logic                      busy_o,
    output logic [15:0]               timeout_cnt_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    ga_arb_state_e   state_q, state_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic [IdxW-1:0] grant_idx_q, grant_idx_d;
    ga_req_t         hold_req_q, hold_req_d;
    ga_resp_t        hold_resp_q, hold_resp_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]     timeout_cnt_q, timeout_cnt_d;

    logic [NumReq-1:0] req_vld;
    logic              pick_vld;
    logic [IdxW-1:0]   pick_idx;

    always_comb begin
        req_vld = '0;
        for (int k = 0; k < NumReq; k++) begin
            req_vld[k] = req_i[k].valid;
        end
    end

    ga_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .req_vec_i   (req_vld),
        .last_idx_i  (last_grant_q),
        .grant_vld_o (pick_vld),
        .grant_idx_o (pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_idx_d   = grant_idx_q;
        hold_req_d    = hold_req_q;
        hold_resp_d   = hold_resp_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        req_ready_o   = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_d               = ARB_ISSUE;
                    last_grant_d          = pick_idx;
                    grant_idx_d           = pick_idx;
                    hold_req_d            = req_i[pick_idx];
                    hold_resp_d           = '0;
                    req_ready_o[pick_idx] = 1'b1;
                end
            end
            ARB_ISSUE: begin
                state_d    = ARB_WAIT;
                wait_cnt_d = '0;
            end
            ARB_WAIT: begin
                if (cop_resp_i.valid) begin
                    state_d     = ARB_RESP;
                    hold_resp_d = cop_resp_i;
                end else if (wait_cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d           = ARB_RESP;
                    hold_resp_d       = '0;
                    hold_resp_d.error = 1'b1;
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            ARB_RESP:  state_d = ARB_DRAIN;
            ARB_DRAIN: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase

        // A reset edge discards any capture, so the acceptance pulse must not show.
        if (rst_i) begin
            req_ready_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARB_IDLE;
            last_grant_q  <= IdxW'(NumReq - 1);
            grant_idx_q   <= '0;
            hold_req_q    <= '0;
            hold_resp_q   <= '0;
            wait_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_idx_q   <= grant_idx_d;
            hold_req_q    <= hold_req_d;
            hold_resp_q   <= hold_resp_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign busy_o        = (state_q != ARB_IDLE);
    assign grant_idx_o   = grant_idx_q;
    assign timeout_cnt_o = timeout_cnt_q;

    always_comb begin
        cop_req_o = '0;
        if (state_q == ARB_ISSUE) begin
            cop_req_o       = hold_req_q;
            cop_req_o.valid = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            resp_o[k]       = '0;
            resp_o[k].ready = req_ready_o[k];
            if (IdxW'(k) == grant_idx_q) begin
                if (state_q == ARB_RESP) begin
                    resp_o[k]       = hold_resp_q;
                    resp_o[k].valid = 1'b1;
                    resp_o[k].ready = req_ready_o[k];
                end
                resp_o[k].busy = busy_o;
            end
        end
    end

endmodule

// File: tb/tb_ga_req_arbiter.sv
// Directed bench for ga_req_arbiter with four requesters and an 8-cycle timeout.
module tb_ga_req_arbiter;
    import ga_pkg::*;

    logic        clk;
    logic        rst;
    ga_req_t     req [4];
    logic [3:0]  req_ready;
    ga_resp_t    resp [4];
    ga_req_t     cop_req;
    ga_resp_t    cop_resp;
    logic [1:0]  gidx;
    logic        busy;
    logic [15:0] tcnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ga_req_arbiter #(
        .NumReq        (4),
        .TimeoutCycles (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_ready_o   (req_ready),
        .resp_o        (resp),
        .cop_req_o     (cop_req),
        .cop_resp_i    (cop_resp),
        .grant_idx_o   (gidx),
        .busy_o        (busy),
        .timeout_cnt_o (tcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 4; k++) req[k] = '0;
    endtask

    task automatic test_reset();
        logic any_nz;
        rst = 1'b1;
        clear_reqs();
        cop_resp = '0;
        cyc();
        cyc();
        req[0].valid = 1'b1;
        #2;
        total_cnt++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready got=%b exp=0000", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
        else pass_cnt++;
        total_cnt++;
        if (cop_req !== '0) $display("FAIL reset_cop_req got=%h exp=0", cop_req);
        else pass_cnt++;
        total_cnt++;
        if (gidx !== 2'd0 || tcnt !== 16'd0) $display("FAIL reset_idx_tcnt got=%0d/%0d exp=0/0", gidx, tcnt);
        else pass_cnt++;
        any_nz = 1'b0;
        for (int k = 0; k < 4; k++) if (resp[k] !== '0) any_nz = 1'b1;
        total_cnt++;
        if (any_nz !== 1'b0) $display("FAIL reset_resp got=nonzero exp=all zero");
        else pass_cnt++;
        cyc();
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_contention();
        int n;
        int exp;
        int resp_count;
        logic other_vld;
        resp_count = 0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            req[k].valid     = 1'b1;
            req[k].op        = GA_OP_MUL;
            req[k].operand_a = 32'(k);
            req[k].operand_b = 32'd1;
        end
        for (int t = 0; t < 8; t++) begin
            exp = t % 4;
            #2;
            n = 0;
            while (req_ready === 4'b0000 && n < 20) begin
                cyc();
                #2;
                n++;
            end
            total_cnt++;
            if (req_ready !== (4'b0001 << exp)) $display("FAIL rr_ready t=%0d got=%b exp=%b", t, req_ready, 4'b0001 << exp);
            else pass_cnt++;
            cyc();
            #2;
            total_cnt++;
            if (gidx !== exp[1:0] || cop_req.operand_a !== 32'(exp)) $display("FAIL rr_issue t=%0d got=%0d/%0d exp=%0d", t, gidx, cop_req.operand_a, exp);
            else pass_cnt++;
            cyc();
            cyc();
            cop_resp        = '0;
            cop_resp.valid  = 1'b1;
            cop_resp.result = 32'(100 + t);
            cyc();
            cop_resp = '0;
            #2;
            if (resp[exp].valid === 1'b1 && resp[exp].result === 32'(100 + t)) resp_count++;
            other_vld = 1'b0;
            for (int k = 0; k < 4; k++) if (k != exp && resp[k] !== '0 && resp[k].valid !== 1'b0) other_vld = 1'b1;
            total_cnt++;
            if (other_vld !== 1'b0) $display("FAIL rr_other_resp t=%0d got=valid exp=none", t);
            else pass_cnt++;
            cyc();
            if (t == 7) clear_reqs();
            cyc();
        end
        total_cnt++;
        if (resp_count !== 8) $display("FAIL rr_resp_count got=%0d exp=8", resp_count);
        else pass_cnt++;
    endtask

    task automatic test_single();
        cyc();
        req[0].valid     = 1'b1;
        req[0].op        = GA_OP_ADD;
        req[0].operand_a = 32'd2;
        req[0].operand_b = 32'd3;
        #2;
        total_cnt++;
        if (req_ready !== 4'b0001 || resp[0].ready !== 1'b1) $display("FAIL single_ready got=%b exp=0001", req_ready);
        else pass_cnt++;
        cyc();
        req[0] = '0;
        #2;
        total_cnt++;
        if (cop_req.valid !== 1'b1 || cop_req.op !== GA_OP_ADD || cop_req.operand_a !== 32'd2 || cop_req.operand_b !== 32'd3)
            $display("FAIL single_issue got=%h exp=valid ADD 2 3", cop_req);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1 || resp[0].busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy);
        else pass_cnt++;
        cyc();
        #2;
        total_cnt++;
        if (cop_req !== '0) $display("FAIL single_issue_pulse got=%h exp=0", cop_req);
        else pass_cnt++;
        cyc();
        cyc();
        cop_resp        = '0;
        cop_resp.valid  = 1'b1;
        cop_resp.result = 32'd5;
        #2;
        total_cnt++;
        if (resp[0].valid !== 1'b0) $display("FAIL single_early_resp got=%b exp=0", resp[0].valid);
        else pass_cnt++;
        cyc();
        cop_resp = '0;
        #2;
        total_cnt++;
        if (resp[0].valid !== 1'b1 || resp[0].result !== 32'd5 || resp[0].error !== 1'b0)
            $display("FAIL single_resp got=v%b r%0d e%b exp=v1 r5 e0", resp[0].valid, resp[0].result, resp[0].error);
        else pass_cnt++;
        total_cnt++;
        if (resp[1] !== '0 || resp[2] !== '0 || resp[3] !== '0) $display("FAIL single_nongrant got=nonzero exp=0");
        else pass_cnt++;
        cyc();
        #2;
        total_cnt++;
        if (resp[0].valid !== 1'b0 || cop_req.valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL single_drain got=v%b c%b b%b exp=v0 c0 b1", resp[0].valid, cop_req.valid, busy);
        else pass_cnt++;
        cyc();
        #2;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        cyc();
        req[2].valid     = 1'b1;
        req[2].op        = GA_OP_SUB;
        req[2].operand_a = 32'd9;
        #2;
        total_cnt++;
        if (req_ready !== 4'b0100) $display("FAIL to_ready got=%b exp=0100", req_ready);
        else pass_cnt++;
        cyc();
        req[2] = '0;
        repeat (8) cyc();
        #2;
        total_cnt++;
        if (resp[2].valid !== 1'b0 || busy !== 1'b1) $display("FAIL to_last_wait got=v%b b%b exp=v0 b1", resp[2].valid, busy);
        else pass_cnt++;
        cyc();
        #2;
        total_cnt++;
        if (resp[2].valid !== 1'b1 || resp[2].error !== 1'b1 || resp[2].result !== 32'd0)
            $display("FAIL to_resp got=v%b e%b r%0d exp=v1 e1 r0", resp[2].valid, resp[2].error, resp[2].result);
        else pass_cnt++;
        total_cnt++;
        if (tcnt !== 16'd1) $display("FAIL to_count got=%0d exp=1", tcnt);
        else pass_cnt++;
        cyc();
        cyc();
        req[3].valid     = 1'b1;
        req[3].operand_a = 32'd4;
        #2;
        total_cnt++;
        if (req_ready !== 4'b1000) $display("FAIL to_next_ready got=%b exp=1000", req_ready);
        else pass_cnt++;
        cyc();
        req[3] = '0;
        cyc();
        cyc();
        cop_resp          = '0;
        cop_resp.valid    = 1'b1;
        cop_resp.result   = 32'd42;
        cop_resp.overflow = 1'b1;
        cyc();
        cop_resp = '0;
        #2;
        total_cnt++;
        if (resp[3].valid !== 1'b1 || resp[3].result !== 32'd42 || resp[3].error !== 1'b0 || resp[3].overflow !== 1'b1)
            $display("FAIL to_next_resp got=v%b r%0d e%b o%b exp=v1 r42 e0 o1", resp[3].valid, resp[3].result, resp[3].error, resp[3].overflow);
        else pass_cnt++;
        total_cnt++;
        if (tcnt !== 16'd1) $display("FAIL to_count_hold got=%0d exp=1", tcnt);
        else pass_cnt++;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid();
        logic any_nz;
        cyc();
        req[0].valid     = 1'b1;
        req[0].operand_a = 32'd7;
        cyc();
        req[0] = '0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        total_cnt++;
        if (busy !== 1'b0 || cop_req !== '0) $display("FAIL rstmid_state got=b%b c%h exp=b0 c0", busy, cop_req);
        else pass_cnt++;
        any_nz = 1'b0;
        for (int k = 0; k < 4; k++) if (resp[k] !== '0) any_nz = 1'b1;
        total_cnt++;
        if (any_nz !== 1'b0) $display("FAIL rstmid_resp got=nonzero exp=all zero");
        else pass_cnt++;
        total_cnt++;
        if (tcnt !== 16'd0 || gidx !== 2'd0) $display("FAIL rstmid_regs got=%0d/%0d exp=0/0", tcnt, gidx);
        else pass_cnt++;
        cyc();
        cop_resp        = '0;
        cop_resp.valid  = 1'b1;
        cop_resp.result = 32'd9;
        cyc();
        cop_resp = '0;
        #2;
        any_nz = 1'b0;
        for (int k = 0; k < 4; k++) if (resp[k].valid !== 1'b0) any_nz = 1'b1;
        total_cnt++;
        if (any_nz !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_late_resp got=v%b b%b exp=v0 b0", any_nz, busy);
        else pass_cnt++;
    endtask

    task automatic test_stray_and_rotation();
        logic any_v;
        cyc();
        cop_resp        = '0;
        cop_resp.valid  = 1'b1;
        cop_resp.result = 32'd7;
        cyc();
        cop_resp = '0;
        #2;
        any_v = 1'b0;
        for (int k = 0; k < 4; k++) if (resp[k].valid !== 1'b0) any_v = 1'b1;
        total_cnt++;
        if (any_v !== 1'b0 || busy !== 1'b0 || cop_req !== '0) $display("FAIL stray got=v%b b%b exp=v0 b0", any_v, busy);
        else pass_cnt++;
        cyc();
        req[1].valid     = 1'b1;
        req[1].operand_a = 32'd1;
        req[2].valid     = 1'b1;
        req[2].operand_a = 32'd2;
        #2;
        total_cnt++;
        if (req_ready !== 4'b0010) $display("FAIL rot_after_reset got=%b exp=0010", req_ready);
        else pass_cnt++;
        cyc();
        clear_reqs();
        #2;
        total_cnt++;
        if (cop_req.valid !== 1'b1 || cop_req.operand_a !== 32'd1 || gidx !== 2'd1) $display("FAIL rot_issue got=%h exp=req1", cop_req);
        else pass_cnt++;
        cyc();
        cyc();
        cop_resp        = '0;
        cop_resp.valid  = 1'b1;
        cop_resp.result = 32'd11;
        cyc();
        cop_resp = '0;
        #2;
        total_cnt++;
        if (resp[1].valid !== 1'b1 || resp[1].result !== 32'd11) $display("FAIL rot_resp got=v%b r%0d exp=v1 r11", resp[1].valid, resp[1].result);
        else pass_cnt++;
        cyc();
        #2;
        total_cnt++;
        if (cop_req.valid !== 1'b0 || resp[1].valid !== 1'b0) $display("FAIL rot_drain got=c%b v%b exp=c0 v0", cop_req.valid, resp[1].valid);
        else pass_cnt++;
        cyc();
    endtask

    initial begin
        rst      = 1'b1;
        cop_resp = '0;
        for (int k = 0; k < 4; k++) req[k] = '0;
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_reset_mid();
        test_stray_and_rotation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
